// File: rtl/thd_sweep_controller.sv
// thd_sweep_controller
// Sequencer for the THD measurement chain (sine generator -> FIR -> capture sink).
// Each step runs four phases. FLUSH holds the generator and FIR in reset. SETTLE
// discards FIR transient samples. CAPTURE delivers a fixed number of samples over a
// valid/ready handshake. NEXT raises the amplitude for the following step.
// Sink backpressure freezes the sample strobe, so no sample is lost.
// Build option: define THD_SWEEP_LOOP_EN to restart the sweep automatically after
// DONE. Without it the controller parks in DONE until start.
module thd_sweep_controller #(
   parameter int unsigned           AMP_WIDTH       = 16,
   parameter int unsigned           NUM_STEPS       = 8,
   parameter logic [AMP_WIDTH-1:0]  AMP_START       = 16'd4096,
   parameter logic [AMP_WIDTH-1:0]  AMP_STEP        = 16'd4096,
   parameter int unsigned           FLUSH_CYCLES    = 4,
   parameter int unsigned           SETTLE_SAMPLES  = 64,
   parameter int unsigned           CAPTURE_SAMPLES = 1024,
   parameter int unsigned           CLK_DIV         = 1,
   localparam int unsigned          STEP_W          = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic                 sample_en,
   output logic                 gen_rst,
   output logic [AMP_WIDTH-1:0] amplitude,
   output logic                 capture_valid,
   input  logic                 capture_ready,
   output logic [STEP_W-1:0]    step_idx,
   output logic                 busy,
   output logic                 sweep_done
);

   // One shared counter serves the flush, settle and capture phases.
   localparam int unsigned CNT_MAX_A = (FLUSH_CYCLES > SETTLE_SAMPLES) ? FLUSH_CYCLES : SETTLE_SAMPLES;
   localparam int unsigned CNT_MAX   = (CNT_MAX_A > CAPTURE_SAMPLES) ? CNT_MAX_A : CAPTURE_SAMPLES;
   localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
   localparam int unsigned DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [CNT_W-1:0]  FLUSH_LAST  = CNT_W'(FLUSH_CYCLES - 1);
   localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_SAMPLES - 1);
   localparam logic [CNT_W-1:0]  CAP_LAST    = CNT_W'(CAPTURE_SAMPLES - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST    = DIV_W'(CLK_DIV - 1);
   localparam logic [STEP_W-1:0] LAST_STEP   = STEP_W'(NUM_STEPS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FLUSH,
      S_SETTLE,
      S_CAPTURE,
      S_NEXT,
      S_DONE
   } state_t;

   state_t               state, state_nx;
   logic [CNT_W-1:0]     cnt, cnt_nx;
   logic [DIV_W-1:0]     div, div_nx, div_adv;
   logic                 strobe_due;
   logic                 gen_rst_nx, sample_en_nx, capture_valid_nx, sweep_done_nx, busy_nx;
   logic [AMP_WIDTH-1:0] amplitude_nx;
   logic [STEP_W-1:0]    step_nx;

   // Amplitude increment that clamps at full scale instead of wrapping.
   function automatic logic [AMP_WIDTH-1:0] amp_sat_add(input logic [AMP_WIDTH-1:0] a,
                                                        input logic [AMP_WIDTH-1:0] b);
      logic [AMP_WIDTH:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[AMP_WIDTH] ? {AMP_WIDTH{1'b1}} : sum[AMP_WIDTH-1:0];
   endfunction

   // Sample divider: a strobe is due when the divider reaches its last count.
   always_comb begin
      strobe_due = (div == DIV_LAST);
      div_adv    = strobe_due ? '0 : div + 1'b1;
   end

   // Next-state and next-output logic. Every output is registered from these values.
   always_comb begin
      state_nx         = state;
      cnt_nx           = cnt;
      div_nx           = div;
      gen_rst_nx       = gen_rst;
      sample_en_nx     = 1'b0;
      capture_valid_nx = 1'b0;
      sweep_done_nx    = 1'b0;
      amplitude_nx     = amplitude;
      step_nx          = step_idx;

      if (abort) begin
         state_nx     = S_IDLE;
         gen_rst_nx   = 1'b1;
         amplitude_nx = AMP_START;
         step_nx      = '0;
         cnt_nx       = '0;
         div_nx       = '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               gen_rst_nx = 1'b1;
               if (start) begin
                  state_nx     = S_FLUSH;
                  step_nx      = '0;
                  amplitude_nx = AMP_START;
                  cnt_nx       = '0;
               end
            end
            S_FLUSH: begin
               gen_rst_nx = 1'b1;
               if (cnt == FLUSH_LAST) begin
                  state_nx   = S_SETTLE;
                  gen_rst_nx = 1'b0;
                  cnt_nx     = '0;
                  div_nx     = '0;
               end else begin
                  cnt_nx = cnt + 1'b1;
               end
            end
            S_SETTLE: begin
               gen_rst_nx   = 1'b0;
               div_nx       = div_adv;
               sample_en_nx = strobe_due;
               // Strobes are counted as they appear on sample_en.
               if (sample_en) begin
                  if (cnt == SETTLE_LAST) begin
                     state_nx         = S_CAPTURE;
                     cnt_nx           = '0;
                     capture_valid_nx = strobe_due;
                  end else begin
                     cnt_nx = cnt + 1'b1;
                  end
               end
            end
            S_CAPTURE: begin
               gen_rst_nx = 1'b0;
               if (capture_valid && !capture_ready) begin
                  // Stall: hold the strobe and freeze divider and counter.
                  sample_en_nx     = 1'b1;
                  capture_valid_nx = 1'b1;
               end else if (capture_valid && (cnt == CAP_LAST)) begin
                  cnt_nx = '0;
                  div_nx = '0;
                  if (step_idx == LAST_STEP) begin
                     state_nx      = S_DONE;
                     gen_rst_nx    = 1'b1;
                     sweep_done_nx = 1'b1;
                  end else begin
                     state_nx = S_NEXT;
                  end
               end else begin
                  if (capture_valid) begin
                     cnt_nx = cnt + 1'b1;
                  end
                  div_nx           = div_adv;
                  sample_en_nx     = strobe_due;
                  capture_valid_nx = strobe_due;
               end
            end
            S_NEXT: begin
               // New step and amplitude land together with gen_rst rising.
               state_nx     = S_FLUSH;
               gen_rst_nx   = 1'b1;
               step_nx      = step_idx + 1'b1;
               amplitude_nx = amp_sat_add(amplitude, AMP_STEP);
               cnt_nx       = '0;
            end
            S_DONE: begin
               gen_rst_nx = 1'b1;
`ifdef THD_SWEEP_LOOP_EN
               state_nx     = S_FLUSH;
               step_nx      = '0;
               amplitude_nx = AMP_START;
               cnt_nx       = '0;
`else
               if (start) begin
                  state_nx     = S_FLUSH;
                  step_nx      = '0;
                  amplitude_nx = AMP_START;
                  cnt_nx       = '0;
               end
`endif
            end
            default: begin
               state_nx   = S_IDLE;
               gen_rst_nx = 1'b1;
            end
         endcase
      end

      busy_nx = (state_nx != S_IDLE) && (state_nx != S_DONE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         div           <= '0;
         gen_rst       <= 1'b1;
         sample_en     <= 1'b0;
         capture_valid <= 1'b0;
         sweep_done    <= 1'b0;
         busy          <= 1'b0;
         amplitude     <= AMP_START;
         step_idx      <= '0;
      end else begin
         state         <= state_nx;
         cnt           <= cnt_nx;
         div           <= div_nx;
         gen_rst       <= gen_rst_nx;
         sample_en     <= sample_en_nx;
         capture_valid <= capture_valid_nx;
         sweep_done    <= sweep_done_nx;
         busy          <= busy_nx;
         amplitude     <= amplitude_nx;
         step_idx      <= step_nx;
      end
   end

endmodule

// File: tb/tb_thd_sweep_controller.sv
// Bench for thd_sweep_controller.
// Reduced parameters: 3 steps, 2 flush clocks, 4 settle and 8 capture samples, divide-by-2.
// A second instance with near-full-scale amplitudes exercises saturation.
// Expected captures are queued when a sweep is started and popped on every completed handshake.
module tb_thd_sweep_controller;

   logic clk = 1'b0;
   logic rst, start, abort, capture_ready;
   logic sample_en, gen_rst, capture_valid, busy, sweep_done;
   logic [15:0] amplitude;
   logic [1:0]  step_idx;
   logic sample_en_s, gen_rst_s, capture_valid_s, busy_s, sweep_done_s;
   logic [15:0] amplitude_s;
   logic [1:0]  step_idx_s;

`ifdef THD_SWEEP_LOOP_EN
   localparam int NSW = 2;
`else
   localparam int NSW = 1;
`endif

   always #5 clk = ~clk;

   thd_sweep_controller #(
      .AMP_WIDTH(16), .NUM_STEPS(3), .AMP_START(16'd100), .AMP_STEP(16'd50),
      .FLUSH_CYCLES(2), .SETTLE_SAMPLES(4), .CAPTURE_SAMPLES(8), .CLK_DIV(2)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sample_en(sample_en), .gen_rst(gen_rst), .amplitude(amplitude),
      .capture_valid(capture_valid), .capture_ready(capture_ready),
      .step_idx(step_idx), .busy(busy), .sweep_done(sweep_done)
   );

   thd_sweep_controller #(
      .AMP_WIDTH(16), .NUM_STEPS(3), .AMP_START(16'hFF00), .AMP_STEP(16'h0100),
      .FLUSH_CYCLES(2), .SETTLE_SAMPLES(4), .CAPTURE_SAMPLES(8), .CLK_DIV(2)
   ) dut_s (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sample_en(sample_en_s), .gen_rst(gen_rst_s), .amplitude(amplitude_s),
      .capture_valid(capture_valid_s), .capture_ready(capture_ready),
      .step_idx(step_idx_s), .busy(busy_s), .sweep_done(sweep_done_s)
   );

   typedef struct packed {
      logic [1:0]  step;
      logic [15:0] amp;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int done_cnt, done_cyc, first_se_cyc, stall_cnt, start_cyc;
   int grst_run = 0;
   int settle_cnt[4], comp_cnt[4], cv_cyc[4], first_comp[4], last_comp[4], grst_len[4];
   logic [15:0] amp_s_at[4];
   logic [15:0] prev_amp = 16'd100;
   bit gap_en = 1'b1;
   bit have_prev;
   logic [1:0] prev_comp_step;
   int prev_comp_cyc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_stats();
      done_cnt = 0; done_cyc = 0; first_se_cyc = -1; stall_cnt = 0; have_prev = 1'b0;
      for (int i = 0; i < 4; i++) begin
         settle_cnt[i] = 0; comp_cnt[i] = 0; cv_cyc[i] = 0;
         first_comp[i] = 0; last_comp[i] = 0; grst_len[i] = 0; amp_s_at[i] = '0;
      end
   endtask

   task automatic push_sweep(input int nsteps);
      exp_t e;
      for (int s = 0; s < nsteps; s++) begin
         for (int k = 0; k < 8; k++) begin
            e.step = 2'(s % 3);
            e.amp  = 16'(100 + 50 * (s % 3));
            sb.push_back(e);
         end
      end
   endtask

   // Observe one clock cycle at the falling edge, then return just after the next rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      cyc++;
      if (sample_en && first_se_cyc < 0) first_se_cyc = cyc;
      if (sample_en && !capture_valid) settle_cnt[step_idx]++;
      if (capture_valid) begin
         cv_cyc[step_idx]++;
         chk("strobe_with_valid", sample_en, 1);
      end
      if (capture_valid && !capture_ready) stall_cnt++;
      if (capture_valid && capture_ready) begin
         chk("sb_nonempty", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("cap_amp", amplitude, e.amp);
            chk("cap_step", step_idx, e.step);
         end
         if (gap_en && have_prev && prev_comp_step == step_idx)
            chk("cap_spacing", cyc - prev_comp_cyc, 2);
         if (comp_cnt[step_idx] == 0) first_comp[step_idx] = cyc;
         last_comp[step_idx] = cyc;
         comp_cnt[step_idx]++;
         have_prev = 1'b1; prev_comp_step = step_idx; prev_comp_cyc = cyc;
      end
      if (capture_valid_s && capture_ready) amp_s_at[step_idx_s] = amplitude_s;
      if (sweep_done) begin
         done_cnt++;
         done_cyc = cyc;
         chk("busy_low_with_done", busy, 0);
      end
      if (gen_rst) grst_run++;
      else begin
         if (grst_run > 0) grst_len[step_idx] = grst_run;
         grst_run = 0;
      end
      if (amplitude !== prev_amp) chk("amp_change_under_gen_rst", gen_rst, 1);
      prev_amp = amplitude;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start_cyc = cyc;
      start = 1'b0;
   endtask

   task automatic run_to_done(input int want, input int budget, input string tag);
      int n;
      n = 0;
      while (done_cnt < want && n < budget) begin
         tick();
         n++;
      end
      chk(tag, n < budget, 1);
   endtask

   task automatic post_sweep();
`ifdef THD_SWEEP_LOOP_EN
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("post_abort_busy", busy, 0);
`else
      repeat (5) tick();
      chk("done_busy_low", busy, 0);
      chk("done_single_pulse", done_cnt, 1);
      chk("done_hold_step", step_idx, 2);
      chk("done_hold_amp", amplitude, 200);
      chk("done_gen_rst", gen_rst, 1);
`endif
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; capture_ready = 1'b1;
      clear_stats();
      #1 rst = 1'b0;
      #2;
      chk("rst_gen_rst", gen_rst, 1);
      chk("rst_sample_en", sample_en, 0);
      chk("rst_capture_valid", capture_valid, 0);
      chk("rst_amplitude", amplitude, 100);
      chk("rst_step_idx", step_idx, 0);
      chk("rst_busy", busy, 0);
      chk("rst_sweep_done", sweep_done, 0);
      chk("rst_amplitude_sat", amplitude_s, 16'hFF00);
      #10;
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (3) tick();

      // Full sweep with the sink always ready: cadence, settle strobes, flush length, latency.
      clear_stats();
      push_sweep(3);
      do_start();
      run_to_done(1, 400, "t1_done_in_budget");
      for (int s = 0; s < 3; s++) begin
         chk("t1_settle_strobes", settle_cnt[s], 4);
         chk("t1_completions", comp_cnt[s], 8);
         chk("t1_valid_cycles", cv_cyc[s], 8);
         chk("t1_capture_span", last_comp[s] - first_comp[s], 14);
      end
      chk("t1_flush_len_step1", grst_len[1], 2);
      chk("t1_flush_len_step2", grst_len[2], 2);
      chk("t2_first_strobe_latency", first_se_cyc - start_cyc, 5);
      chk("t2_first_capture", first_comp[0] - start_cyc, 13);
      chk("t1_sweep_length", done_cyc - start_cyc, 84);
      chk("t1_done_after_last", done_cyc, last_comp[2] + 1);
      chk("t1_sb_drained", sb.size(), 0);
      chk("t5_sat_amp0", amp_s_at[0], 16'hFF00);
      chk("t5_sat_amp1", amp_s_at[1], 16'hFFFF);
      chk("t5_sat_amp2", amp_s_at[2], 16'hFFFF);
      post_sweep();

      // Backpressure: sink drops ready for three clocks on the fifth capture of step 0.
      clear_stats();
      gap_en = 1'b0;
      push_sweep(3);
      do_start();
      n = 0;
      while (comp_cnt[0] < 4 && n < 200) begin tick(); n++; end
      chk("t3_reach_fifth", n < 200, 1);
      capture_ready = 1'b0;
      n = 0;
      while (stall_cnt < 3 && n < 50) begin tick(); n++; end
      chk("t3_stall_seen", n < 50, 1);
      capture_ready = 1'b1;
      run_to_done(1, 400, "t3_done_in_budget");
      chk("t3_completions", comp_cnt[0], 8);
      chk("t3_valid_cycles", cv_cyc[0], 11);
      chk("t3_capture_span", last_comp[0] - first_comp[0], 17);
      chk("t3_step1_span", last_comp[1] - first_comp[1], 14);
      chk("t3_sweep_length", done_cyc - start_cyc, 87);
      chk("t3_sb_drained", sb.size(), 0);
      gap_en = 1'b1;
      post_sweep();

      // Abort mid-capture on step 1, then restart from step 0.
      clear_stats();
      push_sweep(2);
      do_start();
      n = 0;
      while (comp_cnt[1] < 3 && n < 300) begin tick(); n++; end
      chk("t4_reach_step1", n < 300, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t4_capture_valid", capture_valid, 0);
      chk("t4_sample_en", sample_en, 0);
      chk("t4_gen_rst", gen_rst, 1);
      chk("t4_amplitude", amplitude, 100);
      chk("t4_busy", busy, 0);
      chk("t4_step_idx", step_idx, 0);
      chk("t4_sat_amp_reload", amplitude_s, 16'hFF00);
      chk("t4_sb_left", sb.size(), 5);
      sb.delete();
      repeat (10) tick();
      chk("t4_no_sweep_done", done_cnt, 0);
      chk("t4_idle_gen_rst", gen_rst, 1);
      clear_stats();
      push_sweep(3);
      do_start();
      run_to_done(1, 400, "t4_restart_done");
      chk("t4_restart_step0", comp_cnt[0], 8);
      chk("t4_restart_sb", sb.size(), 0);
      post_sweep();

      // Asynchronous reset in the middle of step 1 settling.
      clear_stats();
      push_sweep(3);
      do_start();
      n = 0;
      while (settle_cnt[1] < 2 && n < 300) begin tick(); n++; end
      chk("t6_reach_settle", n < 300, 1);
      chk("t6_pre_amp", amplitude, 150);
      #2 rst = 1'b0;
      #1;
      chk("t6_gen_rst", gen_rst, 1);
      chk("t6_sample_en", sample_en, 0);
      chk("t6_capture_valid", capture_valid, 0);
      chk("t6_amplitude", amplitude, 100);
      chk("t6_step_idx", step_idx, 0);
      chk("t6_busy", busy, 0);
      chk("t6_sweep_done", sweep_done, 0);
      chk("t6_sat_amplitude", amplitude_s, 16'hFF00);
      sb.delete();
      @(negedge clk) rst = 1'b1;
      @(posedge clk);
      #1;
      repeat (2) tick();

      // Free run: two sweeps with looping enabled, one otherwise.
      clear_stats();
      push_sweep(3 * NSW);
      do_start();
      run_to_done(NSW, 700, "t6_sweeps_in_budget");
      chk("t6_sweep_count", done_cnt, NSW);
      chk("t6_sb_drained", sb.size(), 0);
      tick();
`ifdef THD_SWEEP_LOOP_EN
      chk("t6_loop_step0", step_idx, 0);
      chk("t6_loop_busy", busy, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6_loop_abort_idle", busy, 0);
`else
      chk("t6_hold_step", step_idx, 2);
      chk("t6_hold_busy", busy, 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/thd_sweep_controller.md
Name: thd_sweep_controller

Overview:
- Sequencer for the THD measurement chain: sine_wave_generator -> fir_filter -> capture sink.
- Steps the generator amplitude through a programmed sweep and flushes the generator and filter between steps.
- Generates the sample strobe, waits out the FIR settling transient, then opens a capture window for a fixed number of filtered samples per step.
- Capture handshake is valid/ready; backpressure from the sink stalls the whole datapath.

Parameters:
- AMP_WIDTH, 16, width of amplitude word driven to the generator.
- NUM_STEPS, 8, number of amplitude steps per sweep (>=1).
- AMP_START, 16'd4096, amplitude of step 0.
- AMP_STEP, 16'd4096, amplitude increment per step. Saturates at all-ones, no wrap.
- FLUSH_CYCLES, 4, clocks gen_rst is held high per step (>=1).
- SETTLE_SAMPLES, 64, sample strobes discarded after flush. Must be >= FIR tap count.
- CAPTURE_SAMPLES, 1024, sample strobes captured per step (>=1).
- CLK_DIV, 1, clk cycles per sample strobe (>=1). A value of 1 gives a strobe every cycle.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  1-cycle pulse. Begins a sweep from IDLE or DONE; ignored otherwise.
- abort  in  1  level. Forces return to IDLE on the next clk edge.
- sample_en  out  1  1-cycle sample strobe to generator/FIR.
- gen_rst  out  1  active-high reset to generator and FIR.
- amplitude  out  AMP_WIDTH  amplitude_control for the generator.
- capture_valid  out  1  the current filtered output is a capture sample.
- capture_ready  in  1  sink accepts the sample.
- step_idx  out  max(1,$clog2(NUM_STEPS))  current step index.
- busy  out  1  high in any state except IDLE/DONE.
- sweep_done  out  1  1-cycle pulse on entry to DONE.

Behaviour:
- Reset values (rst low, asynchronous):
  - state=IDLE, gen_rst=1, sample_en=0, capture_valid=0.
  - amplitude=AMP_START, step_idx=0, busy=0, sweep_done=0.
  - Divider and sample counters cleared.
- All outputs are registered.
- States:
  - IDLE: gen_rst=1. On start -> FLUSH with step_idx=0, amplitude=AMP_START.
  - FLUSH: gen_rst=1 for FLUSH_CYCLES clocks, then -> SETTLE. Divider cleared on entry.
  - SETTLE: gen_rst=0. Divider runs and sample_en pulses every CLK_DIV clocks, the first strobe CLK_DIV clocks after entry. After SETTLE_SAMPLES strobes -> CAPTURE.
  - CAPTURE:
    - capture_valid=1 in the same cycle as each sample_en.
    - If capture_ready=0 in that cycle: sample_en and capture_valid hold high, and the divider and counters freeze until ready=1. This is a stall, so no sample is lost.
    - A capture completes on (capture_valid & capture_ready).
    - After CAPTURE_SAMPLES completions: if step_idx==NUM_STEPS-1 -> DONE, else -> NEXT.
  - NEXT: one cycle. step_idx+1; amplitude += AMP_STEP, saturating at 2^AMP_WIDTH-1. Then -> FLUSH.
  - DONE: gen_rst=1, sweep_done pulses 1 cycle on entry. amplitude/step_idx hold last values until start. start -> FLUSH with step 0.
- abort in any state -> IDLE next edge:
  - capture_valid/sample_en drop in that cycle's registered update.
  - amplitude reloads AMP_START.
  - No sweep_done pulse.
- Priority: rst > abort > start.
- start while busy is ignored.
- amplitude changes only in NEXT/IDLE/start, never while gen_rst=0.
- Latency: start to first sample_en = 1 + FLUSH_CYCLES + CLK_DIV clocks.

Optional Feature:
- Macro: THD_SWEEP_LOOP_EN.
- Defined: completion of the last step goes through DONE for one cycle (sweep_done pulses), then automatically restarts at step 0 via FLUSH. Runs continuously until abort.
- Undefined: the controller stays in DONE until start.

Test Plan:
- Test parameters: NUM_STEPS=3, AMP_START=100, AMP_STEP=50, FLUSH_CYCLES=2, SETTLE_SAMPLES=4, CAPTURE_SAMPLES=8, CLK_DIV=2.
1. Reset then start, capture_ready tied 1 -> per step exactly 8 capture_valid pulses 2 clocks apart. Amplitudes 100, 150, 200. sweep_done pulses once; busy falls with it.
2. Timing on the same run -> gen_rst high exactly 2 clocks before each step. 4 sample_en pulses with capture_valid=0 precede each capture window. First sample_en 5 clocks after start.
3. Drop capture_ready for 3 clocks on the 5th capture -> sample_en/capture_valid held 3 extra clocks. Still exactly 8 completions; total step time +3.
4. abort mid-CAPTURE on step 1 -> next edge state IDLE, capture_valid=0, gen_rst=1, amplitude=100, no sweep_done. start restarts at step 0.
5. AMP_START=16'hFF00, AMP_STEP=16'h0100, NUM_STEPS=3 -> amplitudes FF00, FFFF, FFFF (saturate, no wrap).
6. rst low mid-SETTLE -> all outputs at reset values immediately, without waiting for clk. With THD_SWEEP_LOOP_EN defined, run 2 full sweeps -> 2 sweep_done pulses and step_idx back to 0.
